// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: imem request/response, decode handshake, redirect.
// master = fetch queue side, slave = memory/decode/execute side.
interface inst_fetch_queue_if #(
  parameter int BIN_DIG = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [BIN_DIG-1:0] imem_req_addr;
  logic               imem_rsp_valid;
  logic [BIN_DIG-1:0] imem_rsp_data;
  logic               dec_valid;
  logic               dec_ready;
  logic [BIN_DIG-1:0] dec_pc;
  logic [BIN_DIG-1:0] dec_inst;
  logic               redirect_valid;
  logic [BIN_DIG-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output dec_valid, dec_pc, dec_inst,
    input  dec_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  dec_valid, dec_pc, dec_inst,
    output dec_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC, credit-limited imem requests, (pc,inst) FIFO to decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when empty.
module inst_fetch_queue #(
  parameter int                 BIN_DIG         = 32,
  parameter int                 DEPTH           = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter logic [BIN_DIG-1:0] RESET_PC        = '0
) (
  input logic CLK,
  input logic RST,
  inst_fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [BIN_DIG-1:0] NOP = BIN_DIG'(32'h13);

  logic [BIN_DIG-1:0] fetch_pc;
  logic [OW-1:0]      outstanding;
  logic [OW-1:0]      discard;
  logic [CW-1:0]      count;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [BIN_DIG-1:0] fifo_pc   [DEPTH];
  logic [BIN_DIG-1:0] fifo_inst [DEPTH];
  logic [BIN_DIG-1:0] pq        [MAX_OUTSTANDING];
  logic [PW-1:0]      pq_rd;
  logic [PW-1:0]      pq_wr;

  logic        req_fire;
  logic        rsp_ok;
  logic        rsp_keep;
  logic        push;
  logic        pop;
  logic [31:0] used;

  function automatic logic [PW-1:0] pq_next(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  // slots already promised: buffered plus live in-flight (stale ones excluded)
  assign used = 32'(count) + 32'(outstanding) - 32'(discard);

  assign bus.imem_req_valid = !RST && !bus.redirect_valid &&
                              (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                              (used < 32'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_ok   = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && (discard == '0) && !bus.redirect_valid;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp = rsp_keep && (count == '0);

  assign bus.dec_valid = ((count != '0) || byp) && !bus.redirect_valid;
  assign bus.dec_pc    = !bus.dec_valid ? '0 :
                         (count != '0) ? fifo_pc[rd_ptr] : pq[pq_rd];
  assign bus.dec_inst  = !bus.dec_valid ? NOP :
                         (count != '0) ? fifo_inst[rd_ptr] :
                         bus.imem_rsp_data;

  assign pop  = bus.dec_valid && bus.dec_ready && (count != '0);
  assign push = rsp_keep && !(byp && bus.dec_ready);
`else
  assign bus.dec_valid = (count != '0) && !bus.redirect_valid;
  assign bus.dec_pc    = bus.dec_valid ? fifo_pc[rd_ptr] : '0;
  assign bus.dec_inst  = bus.dec_valid ? fifo_inst[rd_ptr] : NOP;

  assign pop  = bus.dec_valid && bus.dec_ready;
  assign push = rsp_keep;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= {bus.redirect_pc[BIN_DIG-1:2], 2'b00};
      outstanding <= outstanding - OW'(rsp_ok);
      discard     <= outstanding - OW'(rsp_ok);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + BIN_DIG'(4);
      outstanding <= outstanding + OW'(req_fire) - OW'(rsp_ok);
      if (rsp_ok && (discard != '0))
        discard <= discard - OW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (req_fire)
        pq_wr <= pq_next(pq_wr);
      if (rsp_keep)
        pq_rd <= pq_next(pq_rd);
    end
  end

  // storage needs no reset; validity lives in count and the pointers
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pq[pq_rd];
      fifo_inst[wr_ptr] <= bus.imem_rsp_data;
    end
    if (req_fire)
      pq[pq_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an in-order imem model.
// Expected bypass latency follows IFQ_BYPASS_EN.
module tb_inst_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK;
  logic RST;
  bit   mem_hold;
  int   vectors;
  int   miscompares;
  logic [31:0] mq [$];

  inst_fetch_queue_if #(.BIN_DIG(32)) ifc ();

  inst_fetch_queue #(
    .BIN_DIG(32),
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ifc.imem_req_ready = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // latency-1 in-order memory; mem_hold stalls responses
  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      ifc.imem_rsp_valid <= 1'b0;
      ifc.imem_rsp_data  <= '0;
    end else begin
      if (ifc.imem_req_valid && ifc.imem_req_ready)
        mq.push_back(ifc.imem_req_addr);
      if (mq.size() > 0 && !mem_hold) begin
        ifc.imem_rsp_valid <= 1'b1;
        ifc.imem_rsp_data  <= mem_word(mq[0]);
        void'(mq.pop_front());
      end else begin
        ifc.imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic do_reset(input bit ready, input bit hold);
    @(negedge CLK);
    RST = 1'b1;
    ifc.dec_ready = ready;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    mem_hold = hold;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST = 1'b1;
    ifc.dec_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    mem_hold = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    vectors++;
    if (ifc.dec_inst !== 32'h13) begin
      miscompares++;
      $display("FAIL reset_inst got %h want %h", ifc.dec_inst, 32'h13);
    end
    vectors++;
    if (ifc.dec_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dec_valid got %b want 0", ifc.dec_valid);
    end
    vectors++;
    if (ifc.dec_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_dec_pc got %h want 0", ifc.dec_pc);
    end
    vectors++;
    if (ifc.imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_valid got %b want 0", ifc.imem_req_valid);
    end
    RST = 1'b0;
    #1;
    vectors++;
    if ({ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL first_req got v=%b a=%h want v=1 a=0",
               ifc.imem_req_valid, ifc.imem_req_addr);
    end
  endtask

  task automatic test_streaming;
    int w;
    do_reset(1'b1, 1'b0);
    w = 0;
    while (!ifc.dec_valid && w < 10) begin
      @(negedge CLK);
      #1;
      w++;
    end
    vectors++;
    if (!ifc.dec_valid) begin
      miscompares++;
      $display("FAIL stream_start got dec_valid=0 want 1 within 10");
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({ifc.dec_valid, ifc.dec_pc} !== {1'b1, 32'(i * 4)}) begin
        miscompares++;
        $display("FAIL stream_pc[%0d] got v=%b pc=%h want v=1 pc=%h",
                 i, ifc.dec_valid, ifc.dec_pc, 32'(i * 4));
      end
      vectors++;
      if (ifc.dec_inst !== mem_word(32'(i * 4))) begin
        miscompares++;
        $display("FAIL stream_inst[%0d] got %h want %h",
                 i, ifc.dec_inst, mem_word(32'(i * 4)));
      end
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic test_backpressure;
    int hs;
    int n;
    logic [31:0] exp;
    do_reset(1'b0, 1'b0);
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (ifc.imem_req_valid) hs++;
      @(negedge CLK);
      #1;
    end
    vectors++;
    if (hs !== 4) begin
      miscompares++;
      $display("FAIL bp_requests got %0d want 4", hs);
    end
    vectors++;
    if (ifc.imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_req_stall got %b want 0", ifc.imem_req_valid);
    end
    vectors++;
    if ({ifc.dec_valid, ifc.dec_pc} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0",
               ifc.dec_valid, ifc.dec_pc);
    end
    ifc.dec_ready = 1'b1;
    #1;
    exp = 32'h0;
    n = 0;
    for (int c = 0; c < 30 && n < 8; c++) begin
      if (ifc.dec_valid) begin
        vectors++;
        if (ifc.dec_pc !== exp || ifc.dec_inst !== mem_word(exp)) begin
          miscompares++;
          $display("FAIL bp_drain[%0d] got pc=%h inst=%h want pc=%h inst=%h",
                   n, ifc.dec_pc, ifc.dec_inst, exp, mem_word(exp));
        end
        exp = exp + 32'h4;
        n++;
      end
      @(negedge CLK);
      #1;
    end
    vectors++;
    if (n !== 8) begin
      miscompares++;
      $display("FAIL bp_drain_count got %0d want 8", n);
    end
  endtask

  task automatic test_redirect;
    int n;
    bit seen_req;
    logic [31:0] exp;
    do_reset(1'b1, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    vectors++;
    if ({ifc.imem_req_valid, ifc.dec_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL redir_credit got req=%b dv=%b want 0 0",
               ifc.imem_req_valid, ifc.dec_valid);
    end
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h1002;
    mem_hold = 1'b0;
    @(negedge CLK);
    ifc.redirect_valid = 1'b0;
    #1;
    exp = 32'h1000;
    n = 0;
    seen_req = 1'b0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (ifc.imem_req_valid && !seen_req) begin
        seen_req = 1'b1;
        vectors++;
        if (ifc.imem_req_addr !== 32'h1000) begin
          miscompares++;
          $display("FAIL redir_req_addr got %h want 00001000",
                   ifc.imem_req_addr);
        end
      end
      if (ifc.dec_valid) begin
        vectors++;
        if (ifc.dec_pc !== exp || ifc.dec_inst !== mem_word(exp)) begin
          miscompares++;
          $display("FAIL redir_pop[%0d] got pc=%h inst=%h want pc=%h inst=%h",
                   n, ifc.dec_pc, ifc.dec_inst, exp, mem_word(exp));
        end
        exp = exp + 32'h4;
        n++;
      end
      @(negedge CLK);
      #1;
    end
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("FAIL redir_count got %0d want 2", n);
    end
  endtask

  task automatic test_wrap;
    int n;
    logic [31:0] exp;
    do_reset(1'b1, 1'b0);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (ifc.imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_mask got %b want 0", ifc.imem_req_valid);
    end
    @(negedge CLK);
    ifc.redirect_valid = 1'b0;
    #1;
    vectors++;
    if ({ifc.imem_req_valid, ifc.imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      miscompares++;
      $display("FAIL wrap_req got v=%b a=%h want v=1 a=fffffffc",
               ifc.imem_req_valid, ifc.imem_req_addr);
    end
    exp = 32'hFFFF_FFFC;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (ifc.dec_valid) begin
        vectors++;
        if (ifc.dec_pc !== exp || ifc.dec_inst !== mem_word(exp)) begin
          miscompares++;
          $display("FAIL wrap_pop[%0d] got pc=%h inst=%h want pc=%h inst=%h",
                   n, ifc.dec_pc, ifc.dec_inst, exp, mem_word(exp));
        end
        exp = exp + 32'h4;
        n++;
      end
      @(negedge CLK);
      #1;
    end
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL wrap_count got %0d want 3", n);
    end
  endtask

  task automatic test_bypass_latency;
    do_reset(1'b0, 1'b0);
    @(negedge CLK);
    #1;
    vectors++;
    if (ifc.dec_valid !== BYP) begin
      miscompares++;
      $display("FAIL lat_rsp_cycle got dv=%b want %b", ifc.dec_valid, BYP);
    end
    @(negedge CLK);
    #1;
    vectors++;
    if ({ifc.dec_valid, ifc.dec_pc} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL lat_next_cycle got v=%b pc=%h want v=1 pc=0",
               ifc.dec_valid, ifc.dec_pc);
    end
    vectors++;
    if (ifc.dec_inst !== mem_word(32'h0)) begin
      miscompares++;
      $display("FAIL lat_inst got %h want %h", ifc.dec_inst, mem_word(32'h0));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RST = 1'b1;
    mem_hold = 1'b0;
    ifc.dec_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_bypass_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
